// File: rtl/bist_topmodule.sv
// bist_topmodule
// Two jobs behind one 16-bit LED register:
//   - mode 01: a free-running 16-bit LFSR shown on the LEDs, stepped once
//     every TICK_DIV clocks.
//   - modes 10/11: a built-in self test. One LFSR pattern generator feeds two
//     copies of a small combinational CUT. Each copy is compacted by its own
//     MISR. After BIST_LEN patterns the two signatures are compared.
//   - mode 00: LEDs dark, BIST idle, display LFSR frozen.
// Optional feature macro: BIST_FAULT_INJECT_EN. When it is defined, mode 11
// forces bit 0 of the DUT-path CUT output to 0 (stuck-at-0). The session then
// ends with fail set. When it is undefined, mode 11 behaves like mode 10.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   mode[1:0]  00 idle, 01 LFSR display, 10 BIST, 11 BIST with fault
//   led[15:0]  registered display. It shows the state one clock after the
//              state is reached.
//   bist_state BIST FSM state (0 IDLE, 1 RUN, 2 DONE), exported for debug
module bist_topmodule #(
  parameter int TICK_DIV = 25000000,
  parameter int BIST_LEN = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode,
  output logic [15:0] led,
  output logic [1:0] bist_state
);

  localparam logic [15:0] SEED     = 16'hACE1;
  localparam logic [25:0] TICK_MAX = 26'(TICK_DIV - 1);
  localparam logic [12:0] LEN_MAX  = 13'(BIST_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [1:0]  prev_mode;
  logic [15:0] disp;
  logic [25:0] presc;
  logic [15:0] pgen;
  logic [15:0] sig_dut, sig_ref;
  logic [12:0] count;
  logic [15:0] cut_dut, cut_ref;
  logic [15:0] led_n;
  logic        mode_chg;
  logic        pass;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  // a = p[15:8], b = p[7:0]. The upper 7 bits are a^b and the lower 9 bits
  // are the full a+b sum.
  function automatic logic [15:0] cut_fn(input logic [15:0] p);
    logic [8:0] sum;
    sum = {1'b0, p[15:8]} + {1'b0, p[7:0]};
    return {p[14:8] ^ p[6:0], sum};
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] m,
                                            input logic [15:0] d);
    return {m[0] ^ m[2] ^ m[3] ^ m[5], m[15:1]} ^ d;
  endfunction

  assign bist_state = state;
  assign mode_chg   = (mode != prev_mode);
  assign pass       = (sig_dut == sig_ref);

  // The reference path is never faulted.
  always_comb begin
    cut_ref = cut_fn(pgen);
    cut_dut = cut_fn(pgen);
`ifdef BIST_FAULT_INJECT_EN
    if (mode == 2'b11) cut_dut[0] = 1'b0;
`endif
  end

  // An IDLE state with mode 1x always means a new session. A session that
  // is already running or finished is dropped on any mode change. A new
  // session then starts from IDLE on the next cycle.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (mode[1]) state_n = S_RUN;
      S_RUN: begin
        if (!mode[1] || mode_chg)  state_n = S_IDLE;
        else if (count == LEN_MAX) state_n = S_DONE;
      end
      S_DONE: if (!mode[1] || mode_chg) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    led_n = 16'h0000;
    case (mode)
      2'b00: led_n = 16'h0000;
      2'b01: led_n = disp;
      default: begin
        case (state)
          S_RUN:   led_n = {4'b0000, count[11:0]};
          S_DONE:  led_n = {1'b1, pass, ~pass, 1'b0, sig_dut[11:0]};
          default: led_n = 16'h0000;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      prev_mode <= 2'b00;
      led       <= 16'h0000;
    end else begin
      state     <= state_n;
      prev_mode <= mode;
      led       <= led_n;
    end
  end

  // The prescaler stays at zero outside mode 01. Every entry into mode 01
  // therefore starts a full tick period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      disp  <= SEED;
      presc <= '0;
    end else if (mode == 2'b01) begin
      if (presc == TICK_MAX) begin
        presc <= '0;
        disp  <= lfsr_step(disp);
      end else begin
        presc <= presc + 26'd1;
      end
    end else begin
      presc <= '0;
    end
  end

  // BIST datapath. Every RUN cycle absorbs the current pattern into both
  // MISRs and then advances the generator. The last absorb happens on the
  // edge that moves to DONE. The signatures then hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pgen    <= SEED;
      sig_dut <= 16'h0000;
      sig_ref <= 16'h0000;
      count   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (state_n == S_RUN) begin
            pgen    <= SEED;
            sig_dut <= 16'h0000;
            sig_ref <= 16'h0000;
            count   <= '0;
          end
        end
        S_RUN: begin
          sig_dut <= misr_step(sig_dut, cut_dut);
          sig_ref <= misr_step(sig_ref, cut_ref);
          pgen    <= lfsr_step(pgen);
          count   <= count + 13'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bist_topmodule.sv
// Bench for bist_topmodule with TICK_DIV=4 and BIST_LEN=16.
// It checks the display LFSR against a table of timed vectors. It then runs
// BIST sessions as hand-written sequences. Expected LED values go into a
// queue when stimulus is applied and are popped when the output is sampled.
module tb_bist_topmodule;

  localparam int TICK_DIV = 4;
  localparam int BIST_LEN = 16;

`ifdef BIST_FAULT_INJECT_EN
  localparam bit         FAULT_ON  = 1'b1;
  localparam logic [2:0] EXP_TOP11 = 3'b101;
`else
  localparam bit         FAULT_ON  = 1'b0;
  localparam logic [2:0] EXP_TOP11 = 3'b110;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [15:0] led;
  logic [1:0]  bist_state;

  logic [15:0] exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] disp_model;

  typedef struct {
    logic [1:0]  mode;
    int          cycles;
    logic [15:0] exp_led;
  } vec_t;

  vec_t vecs [0:7];

  always #5 clk = ~clk;

  bist_topmodule #(.TICK_DIV(TICK_DIV), .BIST_LEN(BIST_LEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .led        (led),
    .bist_state (bist_state)
  );

  // ---------------- reference model ----------------
  function automatic logic [15:0] m_lfsr(input logic [15:0] s);
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {fb, s[15:1]};
  endfunction

  function automatic logic [15:0] m_cut(input logic [15:0] p);
    int a, b, sum, x;
    a   = int'(p[15:8]);
    b   = int'(p[7:0]);
    sum = a + b;
    x   = (a ^ b) & 32'h7F;
    return 16'((x << 9) | sum);
  endfunction

  function automatic logic [15:0] m_sig(input bit fault);
    logic [15:0] p, m, c;
    p = 16'hACE1;
    m = 16'h0000;
    for (int i = 0; i < BIST_LEN; i++) begin
      c = m_cut(p);
      if (fault) c[0] = 1'b0;
      m = m_lfsr(m) ^ c;
      p = m_lfsr(p);
    end
    return m;
  endfunction

  // ---------------- drivers / checkers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_led(input string name);
    logic [15:0] e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: led=%h but no expected value queued", name, led);
    end else begin
      e = exp_q.pop_front();
      if (led !== e) begin
        n_err++;
        $display("FAIL %s: led=%h expected %h", name, led, e);
      end
    end
  endtask

  task automatic check_state(input string name, input logic [1:0] e);
    n_cmp++;
    if (bist_state !== e) begin
      n_err++;
      $display("FAIL %s: bist_state=%0d expected %0d", name, bist_state, e);
    end
  endtask

  task automatic check_top(input string name, input logic [2:0] e);
    n_cmp++;
    if (led[15:13] !== e) begin
      n_err++;
      $display("FAIL %s: led[15:13]=%b expected %b", name, led[15:13], e);
    end
  endtask

  // Applies mode m with the FSM in IDLE and follows the whole session.
  task automatic run_session(input logic [1:0] m, input bit fault, input string tag);
    logic [15:0] sd, sr;
    logic        ps;
    mode = m;
    exp_q.push_back(16'h0000);
    tick(1);
    check_led({tag, "_entry"});
    for (int k = 0; k < BIST_LEN; k++) begin
      exp_q.push_back(16'(k));
      tick(1);
      check_led({tag, "_count"});
    end
    sd = m_sig(fault);
    sr = m_sig(1'b0);
    ps = (sd == sr);
    exp_q.push_back({1'b1, ps, ~ps, 1'b0, sd[11:0]});
    tick(1);
    check_led({tag, "_done"});
    check_state({tag, "_done_state"}, 2'd2);
    exp_q.push_back({1'b1, ps, ~ps, 1'b0, sd[11:0]});
    tick(3);
    check_led({tag, "_done_hold"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Display vectors: mode, cycles to advance, expected led afterwards.
    vecs[0] = '{2'b01, 1, 16'hACE1};
    vecs[1] = '{2'b01, 4, 16'h5670};
    vecs[2] = '{2'b01, 4, 16'hAB38};
    vecs[3] = '{2'b01, 4, m_lfsr(16'hAB38)};
    vecs[4] = '{2'b00, 1, 16'h0000};
    vecs[5] = '{2'b00, 3, 16'h0000};
    vecs[6] = '{2'b01, 1, m_lfsr(16'hAB38)};
    vecs[7] = '{2'b01, 4, m_lfsr(m_lfsr(16'hAB38))};
    disp_model = m_lfsr(m_lfsr(16'hAB38));

    // Reset held low: outputs are cleared with no clock edge needed.
    rst  = 1'b0;
    mode = 2'b00;
    #12;
    exp_q.push_back(16'h0000);
    check_led("reset_led");
    check_state("reset_state", 2'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.push_back(16'h0000);
    tick(2);
    check_led("idle_mode00");

    for (int i = 0; i < 8; i++) begin
      mode = vecs[i].mode;
      exp_q.push_back(vecs[i].exp_led);
      tick(vecs[i].cycles);
      check_led($sformatf("disp_vec%0d", i));
    end

    // Fault-free session.
    run_session(2'b10, 1'b0, "bist10");
    check_top("bist10_top", 3'b110);

    mode = 2'b00;
    exp_q.push_back(16'h0000);
    tick(1);
    check_led("done_to_00");
    check_state("done_to_00_state", 2'd0);

    // Session with fault injection, if the macro is defined.
    run_session(2'b11, FAULT_ON, "bist11");
    check_top("bist11_top", EXP_TOP11);

    // Leave RUN at count 5 for mode 01, then return to mode 10.
    mode = 2'b00;
    tick(1);
    mode = 2'b10;
    exp_q.push_back(16'h0000);
    tick(1);
    check_led("abort_entry");
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back(16'(k));
      tick(1);
      check_led("abort_count");
    end
    mode = 2'b01;
    exp_q.push_back(disp_model);
    tick(1);
    check_led("abort_to_01");
    check_state("abort_state", 2'd0);
    run_session(2'b10, 1'b0, "restart");

    // Asynchronous reset in the middle of a session.
    mode = 2'b00;
    tick(1);
    mode = 2'b10;
    tick(5);
    rst = 1'b0;
    #1;
    exp_q.push_back(16'h0000);
    check_led("rst_async_led");
    check_state("rst_async_state", 2'd0);
    tick(2);
    rst = 1'b1;
    run_session(2'b10, 1'b0, "after_rst");
    check_top("after_rst_top", 3'b110);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
